// File: rtl/snail_serializer_if.sv
// Load-side handshake between a word producer and snail_serializer.
// The producer owns load_valid/load_data; the serializer answers with load_ready.
interface snail_serializer_if #(
  parameter int WIDTH = 8
);
  logic             load_valid;
  logic             load_ready;
  logic [WIDTH-1:0] load_data;

  modport master (
    output load_valid,
    output load_data,
    input  load_ready
  );

  modport slave (
    input  load_valid,
    input  load_data,
    output load_ready
  );
endinterface

// File: rtl/snail_serializer.sv
// Parallel-in/serial-out stage feeding the "101" detector one bit per clock.
// Words accepted in the last-bit cycle follow with no idle gap on d.
module snail_serializer #(
  parameter int   WIDTH     = 8,
  parameter bit   MSB_FIRST = 1'b1,
  parameter logic IDLE_BIT  = 1'b0
) (
  input  logic                clk,
  input  logic                rst,
  snail_serializer_if.slave   load,
  output logic                d,
  output logic                bit_valid,
  output logic                last_bit,
  output logic                busy
);

  localparam int             CW   = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);

  typedef enum logic {
    IDLE,
    SHIFT
  } state_t;

  state_t           state, state_next;
  logic [WIDTH-1:0] shreg, shreg_next;
  logic [CW-1:0]    cnt, cnt_next;
  logic             at_last;
  logic             accept;

  assign at_last        = (state == SHIFT) && (cnt == LAST);
  // Ready is held low during reset so no handshake can complete in that cycle.
  assign load.load_ready = !rst && ((state == IDLE) || at_last);
  assign accept         = load.load_valid && load.load_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      shreg <= '0;
      cnt   <= '0;
    end else begin
      state <= state_next;
      shreg <= shreg_next;
      cnt   <= cnt_next;
    end
  end

  always_comb begin
    state_next = state;
    shreg_next = shreg;
    cnt_next   = cnt;
    case (state)
      IDLE: begin
        if (accept) begin
          state_next = SHIFT;
          shreg_next = load.load_data;
          cnt_next   = '0;
        end
      end
      SHIFT: begin
        if (cnt == LAST) begin
          if (accept) begin
            shreg_next = load.load_data;
            cnt_next   = '0;
          end else begin
            state_next = IDLE;
          end
        end else begin
          shreg_next = MSB_FIRST ? (shreg << 1) : (shreg >> 1);
          cnt_next   = cnt + CW'(1);
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    bit_valid = (state == SHIFT);
    busy      = bit_valid;
    last_bit  = at_last;
    if (state == SHIFT) begin
      d = MSB_FIRST ? shreg[WIDTH-1] : shreg[0];
    end else begin
      d = IDLE_BIT;
    end
  end

endmodule

// File: tb/tb_snail_serializer.sv
// Directed bench for snail_serializer: MSB-first and LSB-first instances,
// hand-computed bit streams, plus a reference "101" detector on the MSB stream.
module tb_snail_serializer;

  logic clk;
  logic rst;
  logic msb_d, msb_bv, msb_lb, msb_busy;
  logic lsb_d, lsb_bv, lsb_lb, lsb_busy;
  int   total;
  int   passed;

  snail_serializer_if #(.WIDTH(8)) msb_if ();
  snail_serializer_if #(.WIDTH(8)) lsb_if ();

  snail_serializer #(.WIDTH(8), .MSB_FIRST(1'b1), .IDLE_BIT(1'b0)) dut_msb (
    .clk       (clk),
    .rst       (rst),
    .load      (msb_if),
    .d         (msb_d),
    .bit_valid (msb_bv),
    .last_bit  (msb_lb),
    .busy      (msb_busy)
  );

  snail_serializer #(.WIDTH(8), .MSB_FIRST(1'b0), .IDLE_BIT(1'b0)) dut_lsb (
    .clk       (clk),
    .rst       (rst),
    .load      (lsb_if),
    .d         (lsb_d),
    .bit_valid (lsb_bv),
    .last_bit  (lsb_lb),
    .busy      (lsb_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end else begin
      passed++;
    end
  endtask

  task automatic applyStimulus(input logic valid, input logic [7:0] data);
    msb_if.load_valid = valid;
    msb_if.load_data  = data;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [7:0]  word;
    logic [15:0] stream;
    logic [2:0]  hist;
    int          hits;

    total  = 0;
    passed = 0;
    rst    = 1'b1;
    applyStimulus(1'b1, 8'hFF);
    lsb_if.load_valid = 1'b0;
    lsb_if.load_data  = 8'h00;

    // Reset held two edges with a request pending: nothing may be taken.
    for (int i = 0; i < 2; i++) begin
      step();
      checkOutput($sformatf("rst_d%0d", i), msb_d, 1'b0);
      checkOutput($sformatf("rst_bv%0d", i), msb_bv, 1'b0);
      checkOutput($sformatf("rst_lb%0d", i), msb_lb, 1'b0);
      checkOutput($sformatf("rst_rdy%0d", i), msb_if.load_ready, 1'b0);
    end
    applyStimulus(1'b0, 8'h00);
    rst = 1'b0;
    #1;
    checkOutput("rst_rdy_release", msb_if.load_ready, 1'b1);
    checkOutput("rst_busy", msb_busy, 1'b0);
    checkOutput("lsb_rst_rdy", lsb_if.load_ready, 1'b1);

    // Single MSB-first word; load_data is scrambled right after acceptance.
    word = 8'hA5;
    applyStimulus(1'b1, word);
    step();
    applyStimulus(1'b0, 8'h3C);
    for (int i = 1; i <= 8; i++) begin
      checkOutput($sformatf("single_d%0d", i), msb_d, word[8-i]);
      checkOutput($sformatf("single_bv%0d", i), msb_bv, 1'b1);
      checkOutput($sformatf("single_busy%0d", i), msb_busy, 1'b1);
      checkOutput($sformatf("single_lb%0d", i), msb_lb, (i == 8));
      checkOutput($sformatf("single_rdy%0d", i), msb_if.load_ready, (i == 8));
      step();
    end
    checkOutput("single_idle_d", msb_d, 1'b0);
    checkOutput("single_idle_bv", msb_bv, 1'b0);
    checkOutput("single_idle_rdy", msb_if.load_ready, 1'b1);

    // Back-to-back A5 then 5A with valid held high: 16 bits, no gap.
    stream = 16'hA55A;
    applyStimulus(1'b1, 8'hA5);
    step();
    applyStimulus(1'b1, 8'h5A);
    for (int i = 1; i <= 16; i++) begin
      checkOutput($sformatf("b2b_d%0d", i), msb_d, stream[16-i]);
      checkOutput($sformatf("b2b_bv%0d", i), msb_bv, 1'b1);
      checkOutput($sformatf("b2b_lb%0d", i), msb_lb, (i == 8 || i == 16));
      step();
      if (i == 8) applyStimulus(1'b0, 8'h00);
    end
    checkOutput("b2b_idle_bv", msb_bv, 1'b0);

    // Request for FF raised mid-word must wait for the last-bit cycle.
    applyStimulus(1'b1, 8'h00);
    step();
    applyStimulus(1'b0, 8'h00);
    for (int i = 1; i <= 16; i++) begin
      if (i == 2) applyStimulus(1'b1, 8'hFF);
      if (i == 4) applyStimulus(1'b1, 8'h3C);
      if (i == 6) applyStimulus(1'b1, 8'hFF);
      checkOutput($sformatf("held_d%0d", i), msb_d, (i > 8));
      checkOutput($sformatf("held_bv%0d", i), msb_bv, 1'b1);
      checkOutput($sformatf("held_rdy%0d", i), msb_if.load_ready, (i == 8 || i == 16));
      step();
      if (i == 8) applyStimulus(1'b0, 8'h00);
    end
    checkOutput("held_idle_bv", msb_bv, 1'b0);

    // LSB-first instance with 8'h01.
    lsb_if.load_valid = 1'b1;
    lsb_if.load_data  = 8'h01;
    step();
    lsb_if.load_valid = 1'b0;
    lsb_if.load_data  = 8'h00;
    for (int i = 1; i <= 8; i++) begin
      checkOutput($sformatf("lsb_d%0d", i), lsb_d, (i == 1));
      checkOutput($sformatf("lsb_bv%0d", i), lsb_bv, 1'b1);
      checkOutput($sformatf("lsb_lb%0d", i), lsb_lb, (i == 8));
      step();
    end
    checkOutput("lsb_idle_bv", lsb_bv, 1'b0);

    // Reset at the edge ending bit 3 drops the word; a fresh A5 replays in full.
    word = 8'hA5;
    applyStimulus(1'b1, word);
    step();
    applyStimulus(1'b0, 8'h00);
    for (int i = 1; i <= 3; i++) begin
      checkOutput($sformatf("midrst_d%0d", i), msb_d, word[8-i]);
      if (i < 3) step();
    end
    rst = 1'b1;
    step();
    checkOutput("midrst_d", msb_d, 1'b0);
    checkOutput("midrst_bv", msb_bv, 1'b0);
    checkOutput("midrst_rdy_in_rst", msb_if.load_ready, 1'b0);
    rst = 1'b0;
    #1;
    checkOutput("midrst_rdy", msb_if.load_ready, 1'b1);
    applyStimulus(1'b1, word);
    step();
    applyStimulus(1'b0, 8'h00);
    for (int i = 1; i <= 8; i++) begin
      checkOutput($sformatf("replay_d%0d", i), msb_d, word[8-i]);
      checkOutput($sformatf("replay_lb%0d", i), msb_lb, (i == 8));
      step();
    end

    // Overlapping "101" hits on 8'hA8 land on bits 3 and 5.
    hist = 3'b000;
    hits = 0;
    applyStimulus(1'b1, 8'hA8);
    step();
    applyStimulus(1'b0, 8'h00);
    for (int i = 1; i <= 8; i++) begin
      if (msb_bv) hist = {hist[1:0], msb_d};
      checkOutput($sformatf("det_hit%0d", i), (hist == 3'b101), (i == 3 || i == 5));
      if (hist == 3'b101) hits++;
      step();
    end
    checkOutput("det_hits", hits, 2);

    $display("[TB] %0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
